// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction at a time, serialises its source
// operands onto a shared ALU operand bus, waits for the ALU result with a
// timeout, and offers the result (or a timeout error) downstream.
module alu_issue_ctrl #(
  parameter int BUS_WIDTH      = 32,
  parameter int OPCODE_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] instr_op,
  input  logic [BUS_WIDTH-1:0]    instr_rs1,
  input  logic [BUS_WIDTH-1:0]    instr_rs2,
  input  logic [BUS_WIDTH-1:0]    instr_imm,
  input  logic                    instr_use_imm,
  output logic [BUS_WIDTH-1:0]    imme_value,
  output logic [BUS_WIDTH-1:0]    rs_data,
  output logic                    rs_data_sel,
  output logic                    rs_data_valid,
  output logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [BUS_WIDTH-1:0]    alu_out,
  input  logic                    alu_valid_out,
  input  logic                    op_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [BUS_WIDTH-1:0]    res_data,
  output logic                    res_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_RS1 = 3'd1,
    SEND_RS2 = 3'd2,
    WAIT_RES = 3'd3,
    RESP     = 3'd4
  } state_t;

  // Counter value on the last permitted WAIT_RES cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;

  logic [OPCODE_WIDTH-1:0] op_q;
  logic [BUS_WIDTH-1:0]    rs1_q;
  logic [BUS_WIDTH-1:0]    rs2_q;
  logic [BUS_WIDTH-1:0]    imm_q;
  logic                    use_imm_q;
  logic [7:0]              wait_cnt_q;
  logic                    done_seen_q;
  logic                    hs_done_q;
  logic [BUS_WIDTH-1:0]    res_data_q;
  logic                    res_err_q;

  logic                    accept;
  logic                    alu_hit;
  logic                    timeout;
  logic                    res_fire;
  logic                    resp_exit;

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign alu_hit     = (state_q == WAIT_RES) && alu_valid_out;
  assign timeout     = (state_q == WAIT_RES) && !alu_valid_out &&
                       (wait_cnt_q == TIMEOUT_LAST);
  assign res_valid   = (state_q == RESP) && !hs_done_q;
  assign res_fire    = res_valid && res_ready;
  // RESP is left once the result has been taken (now or earlier) and the ALU
  // has signalled completion (earlier or in this very cycle).
  assign resp_exit   = (state_q == RESP) && (res_fire || hs_done_q) &&
                       (done_seen_q || op_done);

  assign res_data    = res_data_q;
  assign res_err     = res_err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and operand-bus / ALU control outputs.
  always_comb begin
    state_d       = state_q;
    rs_data       = '0;
    rs_data_sel   = 1'b0;
    rs_data_valid = 1'b0;
    op_code       = '0;
    imme_value    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SEND_RS1;
      end
      SEND_RS1: begin
        rs_data       = rs1_q;
        rs_data_valid = 1'b1;
        op_code       = op_q;
        imme_value    = imm_q;
        state_d       = use_imm_q ? WAIT_RES : SEND_RS2;
      end
      SEND_RS2: begin
        rs_data       = rs2_q;
        rs_data_sel   = 1'b1;
        rs_data_valid = 1'b1;
        op_code       = op_q;
        imme_value    = imm_q;
        state_d       = WAIT_RES;
      end
      WAIT_RES: begin
        op_code    = op_q;
        imme_value = imm_q;
        if (alu_valid_out || timeout) state_d = RESP;
      end
      RESP: begin
        op_code    = op_q;
        imme_value = imm_q;
        if (resp_exit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction latches, captured on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
    end else if (accept) begin
      op_q      <= instr_op;
      rs1_q     <= instr_rs1;
      rs2_q     <= instr_rs2;
      imm_q     <= instr_imm;
      use_imm_q <= instr_use_imm;
    end
  end

  // WAIT_RES cycle counter; zero whenever outside WAIT_RES so it starts
  // from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT_RES) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Tracks whether the ALU has reported completion of the current instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_seen_q <= 1'b0;
    end else if (accept) begin
      done_seen_q <= 1'b0;
    end else if (timeout) begin
      done_seen_q <= 1'b1;
    end else if (((state_q == WAIT_RES) || (state_q == RESP)) && op_done) begin
      done_seen_q <= 1'b1;
    end
  end

  // Records the downstream handshake so res_valid drops while op_done is
  // still outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_done_q <= 1'b0;
    end else if (accept || resp_exit) begin
      hs_done_q <= 1'b0;
    end else if (res_fire) begin
      hs_done_q <= 1'b1;
    end
  end

  // Result capture: first ALU result in WAIT_RES, or a zero error result on
  // timeout. Later alu_valid_out pulses do not reach this register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else if (alu_hit) begin
      res_data_q <= alu_out;
      res_err_q  <= 1'b0;
    end else if (timeout) begin
      res_data_q <= '0;
      res_err_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl (timeout shortened to 8 cycles).
module tb_alu_issue_ctrl;

  localparam int BW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [OW-1:0] instr_op;
  logic [BW-1:0] instr_rs1;
  logic [BW-1:0] instr_rs2;
  logic [BW-1:0] instr_imm;
  logic          instr_use_imm;
  logic [BW-1:0] imme_value;
  logic [BW-1:0] rs_data;
  logic          rs_data_sel;
  logic          rs_data_valid;
  logic [OW-1:0] op_code;
  logic [BW-1:0] alu_out;
  logic          alu_valid_out;
  logic          op_done;
  logic          res_valid;
  logic          res_ready;
  logic [BW-1:0] res_data;
  logic          res_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [OW-1:0] op;
    logic [BW-1:0] rs1;
    logic [BW-1:0] rs2;
    logic [BW-1:0] imm;
    logic          use_imm;
    logic [BW-1:0] res;   // value the bench ALU returns and the expected res_data
  } vec_t;

  vec_t vecs[4];

  alu_issue_ctrl #(
    .BUS_WIDTH(BW),
    .OPCODE_WIDTH(OW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op(instr_op),
    .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2),
    .instr_imm(instr_imm),
    .instr_use_imm(instr_use_imm),
    .imme_value(imme_value),
    .rs_data(rs_data),
    .rs_data_sel(rs_data_sel),
    .rs_data_valid(rs_data_valid),
    .op_code(op_code),
    .alu_out(alu_out),
    .alu_valid_out(alu_valid_out),
    .op_done(op_done),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an instruction in IDLE and check the operand pulses; returns in WAIT_RES.
  task automatic issue(input vec_t v);
    chk("idle_ready", instr_ready, 1);
    instr_op      = v.op;
    instr_rs1     = v.rs1;
    instr_rs2     = v.rs2;
    instr_imm     = v.imm;
    instr_use_imm = v.use_imm;
    instr_valid   = 1'b1;
    step();
    instr_valid   = 1'b0;
    chk("rs1_valid", rs_data_valid, 1);
    chk("rs1_sel", rs_data_sel, 0);
    chk("rs1_data", rs_data, v.rs1);
    chk("rs1_op", op_code, BW'(v.op));
    chk("rs1_imm", imme_value, v.imm);
    chk("rs1_not_ready", instr_ready, 0);
    step();
    if (!v.use_imm) begin
      chk("rs2_valid", rs_data_valid, 1);
      chk("rs2_sel", rs_data_sel, 1);
      chk("rs2_data", rs_data, v.rs2);
      step();
    end
    chk("wait_no_rs", rs_data_valid, 0);
    chk("wait_rs_data0", rs_data, 0);
    chk("wait_not_ready", instr_ready, 0);
    chk("wait_no_res", res_valid, 0);
    chk("wait_imm", imme_value, v.imm);
  endtask

  // ALU returns result with op_done in the same cycle; result taken at once.
  task automatic complete(input vec_t v);
    alu_out       = v.res;
    alu_valid_out = 1'b1;
    op_done       = 1'b1;
    step();
    alu_valid_out = 1'b0;
    op_done       = 1'b0;
    alu_out       = '0;
    chk("resp_valid", res_valid, 1);
    chk("resp_data", res_data, v.res);
    chk("resp_err", res_err, 0);
    chk("resp_imm", imme_value, v.imm);
    chk("resp_op", op_code, BW'(v.op));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("post_valid", res_valid, 0);
    chk("post_ready", instr_ready, 1);
    chk("post_op0", op_code, 0);
    chk("post_imm0", imme_value, 0);
  endtask

  initial begin
    vecs[0] = '{4'h0, 32'd5,          32'd7,   32'd0,   1'b0, 32'd12};
    vecs[1] = '{4'h1, 32'h10,         32'hAA,  32'h3,   1'b1, 32'h13};
    vecs[2] = '{4'h2, 32'hFFFF_FFFF,  32'd1,   32'h55,  1'b0, 32'h0};
    vecs[3] = '{4'hF, 32'h1234_0000,  32'd0,   32'h5678, 1'b1, 32'h1234_5678};

    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rs1 = '0;
    instr_rs2 = '0; instr_imm = '0; instr_use_imm = 1'b0; alu_out = '0;
    alu_valid_out = 1'b0; op_done = 1'b0; res_ready = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_rs_valid", rs_data_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_op", op_code, 0);
    chk("rst_imm", imme_value, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Table-driven normal transactions.
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i]);
      complete(vecs[i]);
    end

    // Backpressure: result held for 5 cycles; a repeat alu_valid_out is ignored.
    issue(vecs[0]);
    alu_out = 32'd12; alu_valid_out = 1'b1; op_done = 1'b1;
    step();
    alu_valid_out = 1'b0; op_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 32'd12);
      chk("bp_err", res_err, 0);
      chk("bp_not_ready", instr_ready, 0);
      alu_out = 32'hDEAD; alu_valid_out = (i == 2);
      step();
    end
    alu_valid_out = 1'b0; alu_out = '0;
    chk("bp_data_after_repeat", res_data, 32'd12);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_released", instr_ready, 1);
    chk("bp_valid_low", res_valid, 0);

    // Late op_done: valid at N, res_ready at N+1, op_done at N+3.
    issue(vecs[1]);
    alu_out = 32'h13; alu_valid_out = 1'b1;       // cycle N
    step();
    alu_valid_out = 1'b0;
    chk("late_valid", res_valid, 1);              // cycle N+1
    chk("late_data", res_data, 32'h13);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("late_valid_dropped", res_valid, 0);      // cycle N+2
    chk("late_hold_n2", instr_ready, 0);
    chk("late_imm_held", imme_value, 32'h3);
    step();
    chk("late_hold_n3", instr_ready, 0);          // cycle N+3
    chk("late_valid_n3", res_valid, 0);
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("late_ready_back", instr_ready, 1);

    // Timeout after 8 WAIT_RES cycles with no ALU result.
    issue(vecs[3]);
    for (int i = 0; i < 8; i++) begin
      chk("to_wait", res_valid, 0);
      step();
    end
    chk("to_valid", res_valid, 1);
    chk("to_err", res_err, 1);
    chk("to_data", res_data, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("to_idle", instr_ready, 1);

    // Reset in WAIT_RES abandons the instruction.
    issue(vecs[0]);
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_rs_valid", rs_data_valid, 0);
    chk("mr_op", op_code, 0);
    chk("mr_imm", imme_value, 0);
    chk("mr_res_valid", res_valid, 0);
    chk("mr_res_data", res_data, 0);
    chk("mr_res_err", res_err, 0);
    step();
    chk("mr_in_reset_rs", rs_data_valid, 0);
    rst_n = 1'b1;
    step();
    chk("mr_ready", instr_ready, 1);
    chk("mr_no_pulse", rs_data_valid, 0);
    issue(vecs[2]);
    complete(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
